// File: rtl/gnss_ca_pkg.sv
// Shared GPS C/A definitions: code length, G1/G2 feedback, PRN tap table and search FSM states.
package gnss_ca_pkg;

  localparam int unsigned CA_LEN = 1023;
  localparam int unsigned PH_W   = 10;
  localparam int unsigned SAT_W  = 6;
  localparam int unsigned TAP_W  = 4;

  // G2 tap pair (1-based stage numbers); 0/0 marks an invalid PRN
  typedef struct packed {
    logic [TAP_W-1:0] t1;
    logic [TAP_W-1:0] t2;
  } ca_taps_t;

  typedef enum logic [2:0] {IDLE, LOAD, INT, DRAIN, CMP, DONE} ca_state_t;

  // Stage 10 is bit 9; feedback enters stage 1
  function automatic logic [PH_W-1:0] g1_next(input logic [PH_W-1:0] g);
    return {g[8:0], g[2] ^ g[9]};
  endfunction

  function automatic logic [PH_W-1:0] g2_next(input logic [PH_W-1:0] g);
    return {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
  endfunction

  function automatic ca_taps_t ca_taps(input logic [SAT_W-1:0] sat);
    ca_taps_t t;
    case (sat)
      6'd1:    t = {4'd2, 4'd6};
      6'd2:    t = {4'd3, 4'd7};
      6'd3:    t = {4'd4, 4'd8};
      6'd4:    t = {4'd5, 4'd9};
      6'd5:    t = {4'd1, 4'd9};
      6'd6:    t = {4'd2, 4'd10};
      6'd7:    t = {4'd1, 4'd8};
      6'd8:    t = {4'd2, 4'd9};
      6'd9:    t = {4'd3, 4'd10};
      6'd10:   t = {4'd2, 4'd3};
      6'd11:   t = {4'd3, 4'd4};
      6'd12:   t = {4'd5, 4'd6};
      6'd13:   t = {4'd6, 4'd7};
      6'd14:   t = {4'd7, 4'd8};
      6'd15:   t = {4'd8, 4'd9};
      6'd16:   t = {4'd9, 4'd10};
      6'd17:   t = {4'd1, 4'd4};
      6'd18:   t = {4'd2, 4'd5};
      6'd19:   t = {4'd3, 4'd6};
      6'd20:   t = {4'd4, 4'd7};
      6'd21:   t = {4'd5, 4'd8};
      6'd22:   t = {4'd6, 4'd9};
      6'd23:   t = {4'd1, 4'd3};
      6'd24:   t = {4'd4, 4'd6};
      6'd25:   t = {4'd5, 4'd7};
      6'd26:   t = {4'd6, 4'd8};
      6'd27:   t = {4'd7, 4'd9};
      6'd28:   t = {4'd8, 4'd10};
      6'd29:   t = {4'd1, 4'd6};
      6'd30:   t = {4'd2, 4'd7};
      6'd31:   t = {4'd3, 4'd8};
      6'd32:   t = {4'd4, 4'd9};
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ca_chip_gen.sv
// C/A chip generator: seedable G1/G2 pair with PRN tap select; chip output is registered
// so it lines up with a one-cycle-latency sample read issued in the same cycle.
module ca_chip_gen
  import gnss_ca_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PH_W-1:0] g1_seed,
  input  logic [PH_W-1:0] g2_seed,
  input  logic            step,
  input  ca_taps_t        taps,
  output logic            chip_d
);

  logic [PH_W-1:0] g1;
  logic [PH_W-1:0] g2;
  logic            chip_c;

  assign chip_c = g1[9] ^ g2[taps.t1 - TAP_W'(1)] ^ g2[taps.t2 - TAP_W'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1     <= '0;
      g2     <= '0;
      chip_d <= 1'b0;
    end else if (load) begin
      g1 <= g1_seed;
      g2 <= g2_seed;
    end else if (step) begin
      g1     <= g1_next(g1);
      g2     <= g2_next(g2);
      chip_d <= chip_c;
    end
  end

endmodule

// File: rtl/ca_phase_search_ctrl.sv
// Serial C/A code-phase search: per candidate phase, fetch LFSR seeds, correlate 1023 chips
// against the sample RAM and keep the phase with the most agreements.
module ca_phase_search_ctrl
  import gnss_ca_pkg::*;
#(
  parameter int unsigned LFSR_LAT = 2,
  parameter int unsigned ACC_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SAT_W-1:0]  sat,
  input  logic [PH_W-1:0]   phase_start,
  input  logic [PH_W-1:0]   phase_count,
  output logic [PH_W-1:0]   lfsr_phase,
  input  logic [PH_W-1:0]   lfsr_g1,
  input  logic [PH_W-1:0]   lfsr_g2,
  output logic [PH_W-1:0]   samp_addr,
  output logic              samp_rd,
  input  logic              samp_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PH_W-1:0]   best_phase,
  output logic [ACC_W-1:0]  best_corr
);

  localparam int unsigned       LAT_W   = (LFSR_LAT > 2) ? $clog2(LFSR_LAT) : 1;
  localparam logic [PH_W-1:0]   LAST_PH = PH_W'(CA_LEN - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX = ACC_W'(CA_LEN);

  ca_state_t         state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [PH_W-1:0]   remaining;
  logic [ACC_W-1:0]  acc;
  ca_taps_t          taps;

  ca_taps_t          sat_taps_c;
  logic [PH_W-1:0]   start_ph_c;
  logic [PH_W-1:0]   next_ph_c;
  logic              gen_load_c;
  logic              gen_step_c;
  logic              chip_d;
  logic              agree_c;
  logic [ACC_W-1:0]  acc_inc_c;

  assign sat_taps_c = ca_taps(sat);
  assign start_ph_c = (phase_start == PH_W'(CA_LEN)) ? '0 : phase_start;
  assign next_ph_c  = (lfsr_phase == LAST_PH) ? '0 : lfsr_phase + PH_W'(1);
  assign gen_load_c = (state == LOAD) && (lat_cnt == LAT_W'(LFSR_LAT - 1));
  assign gen_step_c = (state == INT);
  assign agree_c    = ~(samp_data ^ chip_d);
  // Saturating accumulate; 1023 is the ceiling for a full code period
  assign acc_inc_c  = (acc >= ACC_MAX) ? acc : acc + ACC_W'(agree_c);

  ca_chip_gen u_gen (
    .clk     (clk),
    .rst_n   (rst),
    .load    (gen_load_c),
    .g1_seed (lfsr_g1),
    .g2_seed (lfsr_g2),
    .step    (gen_step_c),
    .taps    (taps),
    .chip_d  (chip_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      remaining  <= '0;
      acc        <= '0;
      taps       <= '0;
      lfsr_phase <= '0;
      samp_addr  <= '0;
      samp_rd    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      best_phase <= '0;
      best_corr  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        samp_rd <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (sat_taps_c.t1 != '0) begin
                state      <= LOAD;
                lat_cnt    <= '0;
                taps       <= sat_taps_c;
                lfsr_phase <= start_ph_c;
                remaining  <= (phase_count == '0) ? PH_W'(CA_LEN) : phase_count;
                best_corr  <= '0;
                best_phase <= start_ph_c;
                err        <= 1'b0;
              end else begin
                // Invalid PRN: one pass through CMP with nothing to compare, then DONE
                state     <= CMP;
                acc       <= '0;
                remaining <= PH_W'(1);
                err       <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (gen_load_c) begin
              state     <= INT;
              acc       <= '0;
              samp_addr <= '0;
              samp_rd   <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + LAT_W'(1);
            end
          end
          INT: begin
            // Read data for chip 0 arrives in the second INT cycle
            if (samp_addr != '0) acc <= acc_inc_c;
            if (samp_addr == LAST_PH) begin
              state   <= DRAIN;
              samp_rd <= 1'b0;
            end else begin
              samp_addr <= samp_addr + PH_W'(1);
            end
          end
          DRAIN: begin
            acc   <= acc_inc_c;
            state <= CMP;
          end
          CMP: begin
            if (acc > best_corr) begin
              best_corr  <= acc;
              best_phase <= lfsr_phase;
            end
            if (remaining <= PH_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              remaining  <= remaining - PH_W'(1);
              lfsr_phase <= next_ph_c;
              lat_cnt    <= '0;
              state      <= LOAD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ca_phase_search_ctrl.sv
// Directed bench for ca_phase_search_ctrl with a PRN1 code model, seed-table LFSR stand-in and sample RAM.
module tb_ca_phase_search_ctrl;

  localparam int unsigned LEN       = 1023;
  localparam int unsigned LAT       = 2;
  localparam int unsigned PER_PHASE = LAT + 1025;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [5:0]  sat;
  logic [9:0]  phase_start;
  logic [9:0]  phase_count;
  logic [9:0]  lfsr_phase;
  logic [9:0]  lfsr_g1;
  logic [9:0]  lfsr_g2;
  logic [9:0]  samp_addr;
  logic        samp_rd;
  logic        samp_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  best_phase;
  logic [11:0] best_corr;

  ca_phase_search_ctrl #(.LFSR_LAT(LAT), .ACC_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .sat         (sat),
    .phase_start (phase_start),
    .phase_count (phase_count),
    .lfsr_phase  (lfsr_phase),
    .lfsr_g1     (lfsr_g1),
    .lfsr_g2     (lfsr_g2),
    .samp_addr   (samp_addr),
    .samp_rd     (samp_rd),
    .samp_data   (samp_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .best_phase  (best_phase),
    .best_corr   (best_corr)
  );

  always #5 clk = ~clk;

  logic [9:0] g1_tab [LEN];
  logic [9:0] g2_tab [LEN];
  logic       code   [LEN];
  logic       ram    [LEN];
  logic [9:0] phase_log [$];

  int checks   = 0;
  int failures = 0;
  int unsigned busy_cnt;
  bit          rd_seen;

  // Seed lookup registered once: valid on the second LOAD cycle
  always @(posedge clk) begin
    lfsr_g1 <= g1_tab[lfsr_phase];
    lfsr_g2 <= g2_tab[lfsr_phase];
  end

  always @(posedge clk) begin
    if (samp_rd) samp_data <= ram[samp_addr];
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // GPS PRN1: G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10, G2 taps 2 and 6
  task automatic build_tables();
    logic [9:0] a;
    logic [9:0] b;
    a = '1;
    b = '1;
    for (int i = 0; i < int'(LEN); i++) begin
      g1_tab[i] = a;
      g2_tab[i] = b;
      code[i]   = a[9] ^ b[1] ^ b[5];
      a = {a[8:0], a[2] ^ a[9]};
      b = {b[8:0], b[1] ^ b[2] ^ b[5] ^ b[7] ^ b[8] ^ b[9]};
    end
  endtask

  task automatic fill_ram(input int unsigned p);
    for (int i = 0; i < int'(LEN); i++) ram[i] = code[(i + p) % LEN];
  endtask

  function automatic int unsigned agreements(input int unsigned q);
    int unsigned n = 0;
    for (int i = 0; i < int'(LEN); i++) if (ram[i] == code[(i + q) % LEN]) n++;
    return n;
  endfunction

  task automatic expect_best(input int unsigned ps, input int unsigned n,
                             output int unsigned bp, output int unsigned bc);
    int unsigned ph;
    int unsigned a;
    ph = (ps >= LEN) ? 0 : ps;
    bp = ph;
    bc = 0;
    for (int k = 0; k < int'(n); k++) begin
      a = agreements(ph);
      if (a > bc) begin
        bc = a;
        bp = ph;
      end
      ph = (ph == LEN - 1) ? 0 : ph + 1;
    end
  endtask

  // Pulse start, then watch until done; 'poke' re-pulses start mid-search with other parameters
  task automatic run_search(input logic [5:0] s, input logic [9:0] ps, input logic [9:0] pc,
                            input int unsigned budget, input int unsigned poke,
                            output int unsigned cycles, output bit timed_out);
    sat = s; phase_start = ps; phase_count = pc; start = 1'b1;
    rd_seen = 1'b0; busy_cnt = 0; phase_log.delete(); timed_out = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (!done) begin
      if (busy) busy_cnt++;
      if (samp_rd) rd_seen = 1'b1;
      if (samp_rd && samp_addr == 10'd0) phase_log.push_back(lfsr_phase);
      if (cycles == poke) begin
        start = 1'b1; sat = 6'd5; phase_start = 10'd500; phase_count = 10'd7;
      end else begin
        start = 1'b0;
      end
      if (cycles >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  function automatic int unsigned log_at(input int k);
    return (phase_log.size() > k) ? int'(phase_log[k]) : 32'hFFFF;
  endfunction

  initial begin
    int unsigned cyc, bp, bc, n, ph_seen, done_seen;
    bit          to;

    rst = 1'b0; start = 1'b0; abort = 1'b0; sat = '0; phase_start = '0; phase_count = '0;
    build_tables();
    repeat (3) @(posedge clk); #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_samp_rd", samp_rd, 0);
    check_eq("rst_lfsr_phase", lfsr_phase, 0);
    check_eq("rst_best_corr", best_corr, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Invalid PRNs: done two cycles after start, busy one cycle, no RAM reads
    run_search(6'd0, 10'd0, 10'd1, 20, 0, cyc, to);
    check_eq("sat0_cycles", cyc, 2);
    check_eq("sat0_err", err, 1);
    check_eq("sat0_busy_cycles", busy_cnt, 1);
    check_eq("sat0_no_rd", rd_seen, 0);
    @(posedge clk); #1;
    check_eq("sat0_done_pulse", done, 0);
    run_search(6'd33, 10'd0, 10'd1, 20, 0, cyc, to);
    check_eq("sat33_cycles", cyc, 2);
    check_eq("sat33_err", err, 1);
    check_eq("sat33_no_rd", rd_seen, 0);
    @(posedge clk); #1;

    // Three non-peak phases below the true code phase, with a stray start mid-search
    fill_ram(123);
    expect_best(120, 3, bp, bc);
    run_search(6'd1, 10'd120, 10'd3, 3 * PER_PHASE + 50, 500, cyc, to);
    check_eq("t2_timeout", to, 0);
    check_eq("t2_cycles", cyc, 3 * PER_PHASE + 1);
    check_eq("t2_best_phase", best_phase, bp);
    check_eq("t2_best_corr", best_corr, bc);
    check_eq("t2_err_cleared", err, 0);
    check_eq("t2_busy_at_done", busy, 0);
    check_eq("t2_busy_cycles", busy_cnt, 3 * PER_PHASE);
    check_eq("t2_phase0", log_at(0), 120);
    check_eq("t2_phase2", log_at(2), 122);
    @(posedge clk); #1;
    check_eq("t2_done_pulse", done, 0);

    // Phase wrap 1022 -> 0 with the peak at phase 0
    fill_ram(0);
    run_search(6'd1, 10'd1021, 10'd4, 4 * PER_PHASE + 50, 0, cyc, to);
    check_eq("t3_cycles", cyc, 4 * PER_PHASE + 1);
    check_eq("t3_seq0", log_at(0), 1021);
    check_eq("t3_seq1", log_at(1), 1022);
    check_eq("t3_seq2", log_at(2), 0);
    check_eq("t3_seq3", log_at(3), 1);
    check_eq("t3_best_phase", best_phase, 0);
    check_eq("t3_best_corr", best_corr, 1023);
    @(posedge clk); #1;

    // phase_start of 1023 is treated as phase 0
    run_search(6'd1, 10'd1023, 10'd1, PER_PHASE + 50, 0, cyc, to);
    check_eq("t_ps1023_cycles", cyc, PER_PHASE + 1);
    check_eq("t_ps1023_phase", log_at(0), 0);
    check_eq("t_ps1023_best_phase", best_phase, 0);
    check_eq("t_ps1023_best_corr", best_corr, 1023);
    @(posedge clk); #1;

    // Abort (with a simultaneous start) during the second phase's integration
    fill_ram(300);
    sat = 6'd1; phase_start = 10'd299; phase_count = 10'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; ph_seen = 0;
    while (ph_seen < 2 && n < 3 * PER_PHASE) begin
      if (samp_rd && samp_addr == 10'd0) ph_seen++;
      @(posedge clk); #1;
      n++;
    end
    check_eq("t5_reached_phase2", ph_seen, 2);
    repeat (200) @(posedge clk); #1;
    check_eq("t5_in_int", samp_rd, 1);
    abort = 1'b1; start = 1'b1; phase_start = 10'd0;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_samp_rd", samp_rd, 0);
    done_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done || busy) done_seen++;
      @(posedge clk); #1;
    end
    check_eq("t5_no_done", done_seen, 0);
    check_eq("t5_best_phase_kept", best_phase, 299);
    check_eq("t5_best_corr_kept", best_corr, agreements(299));
    run_search(6'd1, 10'd299, 10'd3, 3 * PER_PHASE + 50, 0, cyc, to);
    check_eq("t5_rerun_cycles", cyc, 3 * PER_PHASE + 1);
    check_eq("t5_rerun_best_phase", best_phase, 300);
    check_eq("t5_rerun_best_corr", best_corr, 1023);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the second phase
    fill_ram(0);
    sat = 6'd1; phase_start = 10'd5; phase_count = 10'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; ph_seen = 0;
    while (ph_seen < 2 && n < 3 * PER_PHASE) begin
      if (samp_rd && samp_addr == 10'd0) ph_seen++;
      @(posedge clk); #1;
      n++;
    end
    repeat (10) @(posedge clk); #1;
    check_eq("t6_pre_best_corr", best_corr, agreements(5));
    check_eq("t6_pre_lfsr_phase", lfsr_phase, 6);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_samp_rd", samp_rd, 0);
    check_eq("t6_samp_addr", samp_addr, 0);
    check_eq("t6_lfsr_phase", lfsr_phase, 0);
    check_eq("t6_best_phase", best_phase, 0);
    check_eq("t6_best_corr", best_corr, 0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    check_eq("t6_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
